// File: rtl/fht_addr_seq.sv
// Address and control sequencer for a radix-2 FHT butterfly over ping-pong RAM banks.
// Issues X0/X1/X2 reads plus a twiddle index per cycle and replays Y0/Y1 writes LAT cycles later.
module fht_addr_seq #(
  parameter int LOG2_N = 8,
  parameter int LAT    = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [LOG2_N-1:0] oSTAGE,
  output logic              oRD_VALID,
  output logic              oRD_BANK,
  output logic [LOG2_N-1:0] oRD_ADDR0,
  output logic [LOG2_N-1:0] oRD_ADDR1,
  output logic [LOG2_N-1:0] oRD_ADDR2,
  output logic [LOG2_N-1:0] oTW_IDX,
  output logic              oWR_EN,
  output logic              oWR_BANK,
  output logic [LOG2_N-1:0] oWR_ADDR0,
  output logic [LOG2_N-1:0] oWR_ADDR1
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t            state;
  logic [LOG2_N-1:0] s;
  logic [LOG2_N-1:0] g;
  logic [LOG2_N-1:0] k;
  logic [WCW-1:0]    wcnt;

  logic [LOG2_N-1:0] h;
  logic [LOG2_N-1:0] g_step;
  logic [LOG2_N-1:0] g_nxt;
  logic [LOG2_N-1:0] k_nxt;
  logic              last_k;
  logic              last_g;

  logic              dly_en   [LAT];
  logic              dly_bank [LAT];
  logic [LOG2_N-1:0] dly_a0   [LAT];
  logic [LOG2_N-1:0] dly_a1   [LAT];

  // All four butterfly outputs for stage st, group base gb, offset kk; arithmetic wraps mod N.
  function automatic logic [4*LOG2_N-1:0] bfly_addr(
    input logic [LOG2_N-1:0] st,
    input logic [LOG2_N-1:0] gb,
    input logic [LOG2_N-1:0] kk
  );
    logic [LOG2_N-1:0] hh;
    logic [LOG2_N-1:0] a0;
    logic [LOG2_N-1:0] a1;
    logic [LOG2_N-1:0] a2;
    logic [LOG2_N-1:0] tw;
    hh = LOG2_N'(1) << st;
    a0 = gb + kk;
    a1 = gb + hh + kk;
    a2 = (kk == '0) ? (gb + hh) : (gb + (hh << 1) - kk);
    tw = kk << (LOG2_N'(LOG2_N - 1) - st);
    return {a0, a1, a2, tw};
  endfunction

  // Group base wraps to zero exactly when the last group of the stage has been issued.
  always_comb begin
    h      = LOG2_N'(1) << s;
    g_step = h << 1;
    last_k = (k == (h - LOG2_N'(1)));
    g_nxt  = g + g_step;
    last_g = (g_nxt == '0);
    k_nxt  = last_k ? '0 : (k + LOG2_N'(1));
  end

  assign oBUSY    = (state != IDLE);
  assign oSTAGE   = s;
  assign oRD_BANK = s[0];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state     <= IDLE;
      s         <= '0;
      g         <= '0;
      k         <= '0;
      wcnt      <= '0;
      oDONE     <= 1'b0;
      oRD_VALID <= 1'b0;
      oRD_ADDR0 <= '0;
      oRD_ADDR1 <= '0;
      oRD_ADDR2 <= '0;
      oTW_IDX   <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDONE <= 1'b0;
          if (iSTART) begin
            state     <= RUN;
            s         <= '0;
            g         <= '0;
            k         <= '0;
            oRD_VALID <= 1'b1;
            {oRD_ADDR0, oRD_ADDR1, oRD_ADDR2, oTW_IDX} <= bfly_addr('0, '0, '0);
          end
        end
        RUN: begin
          if (last_k && last_g) begin
            state     <= WAIT;
            oRD_VALID <= 1'b0;
            wcnt      <= '0;
          end else begin
            if (last_k) g <= g_nxt;
            k <= k_nxt;
            {oRD_ADDR0, oRD_ADDR1, oRD_ADDR2, oTW_IDX} <=
              bfly_addr(s, last_k ? g_nxt : g, k_nxt);
          end
        end
        WAIT: begin
          // The final write of the stage retires in this last WAIT cycle.
          if (wcnt == WCW'(LAT - 1)) begin
            if (s == LOG2_N'(LOG2_N - 1)) begin
              state <= DONE;
              oDONE <= 1'b1;
            end else begin
              state     <= RUN;
              s         <= s + LOG2_N'(1);
              g         <= '0;
              k         <= '0;
              oRD_VALID <= 1'b1;
              {oRD_ADDR0, oRD_ADDR1, oRD_ADDR2, oTW_IDX} <=
                bfly_addr(s + LOG2_N'(1), '0, '0);
            end
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        DONE: begin
          oDONE <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line: the read-side values of each cycle reappear LAT cycles later.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < LAT; i++) begin
        dly_en[i]   <= 1'b0;
        dly_bank[i] <= 1'b0;
        dly_a0[i]   <= '0;
        dly_a1[i]   <= '0;
      end
    end else begin
      dly_en[0]   <= oRD_VALID;
      dly_bank[0] <= ~s[0];
      dly_a0[0]   <= oRD_ADDR0;
      dly_a1[0]   <= oRD_ADDR1;
      for (int i = 1; i < LAT; i++) begin
        dly_en[i]   <= dly_en[i-1];
        dly_bank[i] <= dly_bank[i-1];
        dly_a0[i]   <= dly_a0[i-1];
        dly_a1[i]   <= dly_a1[i-1];
      end
    end
  end

  assign oWR_EN    = dly_en[LAT-1];
  assign oWR_BANK  = dly_bank[LAT-1];
  assign oWR_ADDR0 = dly_a0[LAT-1];
  assign oWR_ADDR1 = dly_a1[LAT-1];

endmodule

// File: tb/tb_fht_addr_seq.sv
// Bench for fht_addr_seq: an N=8/LAT=4 and an N=256/LAT=1 instance checked against a
// cycle-indexed arithmetic model, plus directed literal expectations.
module tb_fht_addr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn;
  logic [1:0] start;
  logic [1:0] q_busy, q_done, q_rv, q_rb, q_we, q_wb;
  logic [1:0][7:0] q_st, q_a0, q_a1, q_a2, q_tw, q_w0, q_w1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L  = (gi == 0) ? 3 : 8;
    localparam int LT = (gi == 0) ? 4 : 1;
    logic [L-1:0] st, a0, a1, a2, tw, w0, w1;
    fht_addr_seq #(.LOG2_N(L), .LAT(LT)) u_dut (
      .iCLK(clk), .iRESET(rstn[gi]), .iSTART(start[gi]),
      .oBUSY(q_busy[gi]), .oDONE(q_done[gi]), .oSTAGE(st),
      .oRD_VALID(q_rv[gi]), .oRD_BANK(q_rb[gi]),
      .oRD_ADDR0(a0), .oRD_ADDR1(a1), .oRD_ADDR2(a2), .oTW_IDX(tw),
      .oWR_EN(q_we[gi]), .oWR_BANK(q_wb[gi]), .oWR_ADDR0(w0), .oWR_ADDR1(w1)
    );
    assign q_st[gi] = 8'(st);
    assign q_a0[gi] = 8'(a0);
    assign q_a1[gi] = 8'(a1);
    assign q_a2[gi] = 8'(a2);
    assign q_tw[gi] = 8'(tw);
    assign q_w0[gi] = 8'(w0);
    assign q_w1[gi] = 8'(w1);
  end

  function automatic int lp(input int i);
    return (i == 0) ? 3 : 8;
  endfunction
  function automatic int lat(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Butterfly r (0..N/2-1) of stage s, straight from the loop-nest definition.
  function automatic void bfly(input int n, input int s, input int r,
                               output int a0, output int a1, output int a2, output int tw);
    int h, g, k;
    h  = 1 << s;
    g  = (r / h) * 2 * h;
    k  = r % h;
    a0 = g + k;
    a1 = g + h + k;
    a2 = (k == 0) ? g + h : g + 2 * h - k;
    tw = k * (n / (2 * h));
  endfunction

  // Expected outputs at cycle t after the start-accepting edge (t=0 is the first RUN cycle).
  function automatic void mdl(input int l, input int lt, input int t,
                              output int rv, output int st, output int a0, output int a1,
                              output int a2, output int tw, output int we, output int wb,
                              output int w0, output int w1, output int dn);
    int n, hf, p, tt, ws, x2, xt;
    n = 1 << l; hf = n / 2; p = hf + lt;
    rv = 0; st = -1; a0 = 0; a1 = 0; a2 = 0; tw = 0;
    we = 0; wb = 0; w0 = 0; w1 = 0;
    dn = (t == l * p) ? 1 : 0;
    if (t < l * p) begin
      st = t / p;
      if ((t % p) < hf) begin
        rv = 1;
        bfly(n, st, t % p, a0, a1, a2, tw);
      end
    end
    tt = t - lt;
    if (tt >= 0 && tt < l * p && (tt % p) < hf) begin
      we = 1;
      ws = tt / p;
      wb = (ws + 1) % 2;
      bfly(n, ws, tt % p, w0, w1, x2, xt);
    end
  endfunction

  int act [2];
  int t   [2];
  int h_st[2], h_a0[2], h_a1[2], h_a2[2], h_tw[2];
  int e_busy[2], e_done[2], e_rv[2], e_st[2], e_rb[2], e_a0[2], e_a1[2], e_a2[2], e_tw[2];
  int e_we[2], e_wb[2], e_w0[2], e_w1[2];

  always_comb begin
    int rv, st, a0, a1, a2, tw, we, wb, w0, w1, dn;
    rv = 0; st = 0; a0 = 0; a1 = 0; a2 = 0; tw = 0; we = 0; wb = 0; w0 = 0; w1 = 0; dn = 0;
    for (int i = 0; i < 2; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rv[i] = 0; e_we[i] = 0; e_wb[i] = 0;
      e_w0[i] = 0; e_w1[i] = 0;
      e_st[i] = h_st[i]; e_a0[i] = h_a0[i]; e_a1[i] = h_a1[i];
      e_a2[i] = h_a2[i]; e_tw[i] = h_tw[i];
      if (rstn[i] && act[i] != 0) begin
        mdl(lp(i), lat(i), t[i], rv, st, a0, a1, a2, tw, we, wb, w0, w1, dn);
        e_busy[i] = 1;
        e_done[i] = dn;
        e_rv[i]   = rv;
        if (st >= 0) e_st[i] = st;
        if (rv != 0) begin
          e_a0[i] = a0; e_a1[i] = a1; e_a2[i] = a2; e_tw[i] = tw;
        end
        e_we[i] = we; e_wb[i] = wb; e_w0[i] = w0; e_w1[i] = w1;
      end
      if (!rstn[i]) begin
        e_st[i] = 0; e_a0[i] = 0; e_a1[i] = 0; e_a2[i] = 0; e_tw[i] = 0;
      end
      e_rb[i] = e_st[i] % 2;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        act[i] <= 0; t[i] <= 0;
        h_st[i] <= 0; h_a0[i] <= 0; h_a1[i] <= 0; h_a2[i] <= 0; h_tw[i] <= 0;
      end else begin
        h_st[i] <= e_st[i]; h_a0[i] <= e_a0[i]; h_a1[i] <= e_a1[i];
        h_a2[i] <= e_a2[i]; h_tw[i] <= e_tw[i];
        if (act[i] != 0) begin
          if (t[i] == lp(i) * ((1 << (lp(i) - 1)) + lat(i))) act[i] <= 0;
          else t[i] <= t[i] + 1;
        end else if (start[i]) begin
          act[i] <= 1; t[i] <= 0;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (time %0t)", nm, got, want, $time);
    end
  endtask

  task automatic cmp_cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_busy", i), int'(q_busy[i]), e_busy[i]);
      chk($sformatf("d%0d_done", i), int'(q_done[i]), e_done[i]);
      chk($sformatf("d%0d_rd_valid", i), int'(q_rv[i]), e_rv[i]);
      chk($sformatf("d%0d_stage", i), int'(q_st[i]), e_st[i]);
      chk($sformatf("d%0d_rd_bank", i), int'(q_rb[i]), e_rb[i]);
      chk($sformatf("d%0d_rd_addr0", i), int'(q_a0[i]), e_a0[i]);
      chk($sformatf("d%0d_rd_addr1", i), int'(q_a1[i]), e_a1[i]);
      chk($sformatf("d%0d_rd_addr2", i), int'(q_a2[i]), e_a2[i]);
      chk($sformatf("d%0d_tw_idx", i), int'(q_tw[i]), e_tw[i]);
      chk($sformatf("d%0d_wr_en", i), int'(q_we[i]), e_we[i]);
      if (e_we[i] != 0) begin
        chk($sformatf("d%0d_wr_bank", i), int'(q_wb[i]), e_wb[i]);
        chk($sformatf("d%0d_wr_addr0", i), int'(q_w0[i]), e_w0[i]);
        chk($sformatf("d%0d_wr_addr1", i), int'(q_w1[i]), e_w1[i]);
      end
    end
  endtask

  function automatic int pk(input int b, input int a0, input int a1, input int a2, input int tw);
    return b * 10000 + a0 * 1000 + a1 * 100 + a2 * 10 + tw;
  endfunction

  int exp_rd[12];
  int exp_wr[4];
  int rd_q[$];
  int wr_q[$];
  int cov[8][256];

  initial begin
    int first_we, done_cyc, busy_n, rv0, cnt, nw, ws, bad;
    bit found;
    exp_rd = '{110, 2330, 4550, 6770, 10220, 11332, 14660, 15772, 440, 1571, 2662, 3753};
    exp_wr = '{101, 123, 145, 167};
    rstn  = 2'b00;
    start = 2'b00;
    fork
      forever @(negedge clk) cmp_cycle();
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_busy_d%0d", i), int'(q_busy[i]), 0);
      chk($sformatf("reset_rd_valid_d%0d", i), int'(q_rv[i]), 0);
      chk($sformatf("reset_wr_en_d%0d", i), int'(q_we[i]), 0);
      chk($sformatf("reset_addr0_d%0d", i), int'(q_a0[i]), 0);
    end
    rstn = 2'b11;
    repeat (2) @(negedge clk);

    // Full N=8 run with a stray start while busy.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    first_we = -1; done_cyc = -1; busy_n = 0; rv0 = int'(q_rv[0]);
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      if (q_rv[0]) rd_q.push_back(pk(int'(q_rb[0]), int'(q_a0[0]), int'(q_a1[0]),
                                     int'(q_a2[0]), int'(q_tw[0])));
      if (q_we[0]) begin
        if (first_we < 0) first_we = c;
        wr_q.push_back(int'(q_wb[0]) * 100 + int'(q_w0[0]) * 10 + int'(q_w1[0]));
      end
      if (q_busy[0]) busy_n++;
      if (q_done[0]) done_cyc = c;
      start[0] = (c == 6);
      if (done_cyc < 0) @(negedge clk);
    end
    start[0] = 1'b0;
    chk("small_rd_valid_first_cycle", rv0, 1);
    chk("small_done_cycle", done_cyc, 24);
    chk("small_busy_cycles", busy_n, 25);
    chk("small_first_write_cycle", first_we, 4);
    chk("small_read_count", rd_q.size(), 12);
    chk("small_write_count", wr_q.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("small_read_tuple%0d", i), (i < rd_q.size()) ? rd_q[i] : -1, exp_rd[i]);
    for (int i = 0; i < 4; i++)
      chk($sformatf("small_write_pair%0d", i), (i < wr_q.size()) ? wr_q[i] : -1, exp_wr[i]);
    @(negedge clk);
    chk("small_idle_after_done", int'(q_busy[0]), 0);

    // Abort in stage 1 with an asynchronous reset, then restart.
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (q_st[0] == 8'd1 && q_rv[0]) found = 1;
      else @(negedge clk);
    end
    chk("abort_reached_stage1", int'(found), 1);
    #2 rstn[0] = 1'b0;
    #1;
    chk("abort_busy", int'(q_busy[0]), 0);
    chk("abort_rd_valid", int'(q_rv[0]), 0);
    chk("abort_wr_en", int'(q_we[0]), 0);
    chk("abort_stage", int'(q_st[0]), 0);
    chk("abort_addr1", int'(q_a1[0]), 0);
    chk("abort_tw", int'(q_tw[0]), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rstn[0] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (q_we[0]) cnt++;
    end
    chk("abort_no_writes_after", cnt, 0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("restart_stage", int'(q_st[0]), 0);
    chk("restart_first_tuple", pk(int'(q_rb[0]), int'(q_a0[0]), int'(q_a1[0]),
                                  int'(q_a2[0]), int'(q_tw[0])), 110);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (q_done[0]) found = 1;
      else @(negedge clk);
    end
    chk("restart_done_seen", int'(found), 1);

    // N=256, LAT=1: count writes and per-stage address coverage.
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 256; a++) cov[s][a] = 0;
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    nw = 0; done_cyc = -1;
    for (int c = 0; c < 1200 && done_cyc < 0; c++) begin
      if (q_we[1]) begin
        ws = nw / 128;
        if (ws < 8) begin
          cov[ws][int'(q_w0[1])]++;
          cov[ws][int'(q_w1[1])]++;
        end
        nw++;
      end
      if (q_done[1]) done_cyc = c;
      if (done_cyc < 0) @(negedge clk);
    end
    chk("big_write_count", nw, 1024);
    chk("big_done_cycle", done_cyc, 1032);
    for (int s = 0; s < 8; s++) begin
      bad = 0;
      for (int a = 0; a < 256; a++) if (cov[s][a] != 1) bad++;
      chk($sformatf("big_stage%0d_coverage", s), bad, 0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fht_addr_seq.md
Name: fht_addr_seq

Overview:
- Control and address sequencer directly upstream of the FHT butterfly.
- Walks all LOG2_N radix-2 Hartley stages over a ping-pong pair of data RAM banks.
- Each cycle it issues three operand read addresses (X0, X1, X2) and a twiddle ROM index for the butterfly's sin/cos inputs.
- Replays the matching result write addresses (Y0, Y1) after a fixed pipeline latency, and reports start/busy/done to the top level.

Parameters:
- LOG2_N, 8, log2 of transform length N (N = 2^LOG2_N, minimum 3).
- LAT, 4, cycles from read issue to result write (RAM read latency plus butterfly pipeline), minimum 1.

Ports:
- iCLK  in  1  clock
- iRESET  in  1  asynchronous active-low reset
- iSTART  in  1  single-cycle start request
- oBUSY  out  1  high from accepted start until oDONE
- oDONE  out  1  single-cycle pulse, transform complete
- oSTAGE  out  LOG2_N  current stage index s
- oRD_VALID  out  1  read addresses valid this cycle
- oRD_BANK  out  1  bank read this stage
- oRD_ADDR0  out  LOG2_N  X0 address
- oRD_ADDR1  out  LOG2_N  X1 address
- oRD_ADDR2  out  LOG2_N  X2 address
- oTW_IDX  out  LOG2_N  twiddle index; angle = 2*pi*oTW_IDX/N
- oWR_EN  out  1  write Y0/Y1 this cycle
- oWR_BANK  out  1  bank written
- oWR_ADDR0  out  LOG2_N  Y0 address
- oWR_ADDR1  out  LOG2_N  Y1 address

Behaviour:
- Reset: iRESET is asynchronous, active-low; clock is iCLK. Reset forces state IDLE; all counters, outputs and delay-line contents go to 0. Reset mid-transform aborts the transform, with no further oWR_EN.
- States:
  - IDLE: iSTART=1 -> RUN with s=0, g=0, k=0.
  - RUN: one butterfly issued per cycle, oRD_VALID=1. After the last butterfly of the stage -> WAIT.
  - WAIT: oRD_VALID=0 for exactly LAT cycles. Then -> RUN with s+1, or -> DONE if s=LOG2_N-1.
  - DONE: oDONE=1 for one cycle -> IDLE.
- oBUSY = state != IDLE. iSTART is ignored when not in IDLE.
- Stage s geometry: half-size h = 2^s. Group base g steps 0, 2h, 4h ... N-2h (outer loop). k steps 0..h-1 (inner loop). N/2 RUN cycles per stage.
- Addresses per cycle:
  - ADDR0 = g+k
  - ADDR1 = g+h+k
  - ADDR2 = g+h (k=0), else g+2h-k
  - TW_IDX = k * (N/(2h)), i.e. k shifted left by LOG2_N-1-s
- Address arithmetic is modulo N; results never exceed N-1 by construction.
- Banks: oRD_BANK = s[0]; write bank = ~s[0]. Input data is loaded in bank 0 before start. The result ends in bank LOG2_N[0].
- Write path: oWR_EN, oWR_BANK, oWR_ADDR0 (= ADDR0) and oWR_ADDR1 (= ADDR1) are the RUN-cycle values delayed exactly LAT cycles through a shift register. oWR_EN = oRD_VALID delayed LAT.
- The last write of a stage lands in the last WAIT cycle, so the first read of stage s+1 follows the committed write. No read/write overlap on one bank.
- Total from iSTART-accepting edge to oDONE: LOG2_N*(N/2+LAT) cycles of RUN/WAIT, then oDONE on the next cycle.
- When oRD_VALID=0, read address outputs and oTW_IDX hold their last values. oSTAGE holds during WAIT.

Test Plan:
- Reset mid-RUN (N=8, LAT=4): assert iRESET low in stage 1 -> all outputs 0 immediately, no oWR_EN pulses follow, next iSTART restarts at stage 0.
- Stage 0 (N=8): after iSTART -> 4 RUN cycles with (ADDR0,ADDR1,ADDR2,TW) = (0,1,1,0) (2,3,3,0) (4,5,5,0) (6,7,7,0), RD_BANK=0. oWR_EN pulses 4 cycles later with (0,1) (2,3) (4,5) (6,7), WR_BANK=1.
- Stage 1 (N=8) -> (0,2,2,0) (1,3,3,2) (4,6,6,0) (5,7,7,2), RD_BANK=1.
- Stage 2 (N=8) -> (0,4,4,0) (1,5,7,1) (2,6,6,2) (3,7,5,3), RD_BANK=0, WR_BANK=1.
- Timing (N=8, LAT=4): oDONE pulses exactly 24 cycles after the first RUN cycle. oBUSY is high across all 24 cycles plus the DONE cycle. iSTART pulsed while busy has no effect.
- N=256, LAT=1: count oWR_EN pulses = 8*128. Each stage writes every address 0..255 exactly once. oDONE at cycle 8*(128+1).
